aqed_rd_dup: RTL and testbench
==============================

Name: aqed_rd_dup

Overview:
- Read-side A-QED companion for the memory core; complements the write-side duplicate injector.
- Sits between the read requester and the core read port:
  - forwards read requests;
  - on exec_dup, tags one read as "original" and re-issues the same address later as a "duplicate";
  - tracks outstanding reads in order and captures both returned words.
- Flags a self-consistency failure when the two returns differ and no write intervened.

Parameters:
AW, 9, read address width
DW, 16, read data width
MAX_OUT, 4, maximum outstanding reads (tag FIFO depth, power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clk_en  in  1  global clock enable; all state holds when 0
flush  in  1  aborts in-flight reads and the current check
exec_dup  in  1  arms original capture on next accepted read
ren_in  in  1  read request from requester
addr_in  in  AW  read address from requester
wen_in  in  1  write accepted by core this cycle (taint source)
ren_out  out  1  read strobe to core
addr_out  out  AW  read address to core
valid_out  in  1  core returns read data this cycle (in order)
data_out_in  in  DW  returned read data
stall_out  out  1  requester must hold ren_in (tag FIFO full)
qed_done  out  1  duplicate captured, check result final
qed_valid  out  1  check meaningful (no intervening write)
qed_check  out  1  1 = pass / not yet decided, 0 = mismatch
err_out  out  1  sticky: valid_out with no outstanding read

Behaviour:
- Reset: FSM=IDLE, FIFO empty, captures 0, taint=0; outputs ren_out=0, stall_out=0, qed_done=0, qed_valid=0, qed_check=1, err_out=0.
- Tag FIFO stores 2-bit tag {is_orig, is_dup}, one per issued read.
  - Push when ren_out & clk_en; pop when valid_out & clk_en.
  - Simultaneous push and pop when full is legal and the count is unchanged.
  - stall_out = full & ~pop_this_cycle (combinational).
- Issue (combinational ren_out/addr_out, zero latency):
  - ren_out = ~reset & ~flush & ~stall_out & (ren_in | dup_pending).
  - addr_out = dup_pending ? orig_addr : addr_in.
  - A duplicate takes priority over ren_in in the same cycle; the requester sees stall_out=1 in that cycle.
- FSM:
  - IDLE: exec_dup & ren_out -> latch orig_addr=addr_in, push tag 10, clear taint, go ORIG.
  - ORIG: dup_pending=1. Next cycle with ren_out issues the duplicate with tag 01 -> DUP.
  - DUP: wait for the pop with tag 01; capture dup_data -> DONE.
  - DONE: terminal until reset; further reads are forwarded with tag 00.
- Capture: pop tag 10 -> orig_data=data_out_in; pop tag 01 -> dup_data=data_out_in.
- Taint: set if wen_in & clk_en in any cycle from the original issue through the duplicate issue inclusive. The taint window closes on entering DUP.
- Outputs:
  - qed_done = (state==DONE).
  - qed_valid = qed_done & ~taint.
  - qed_check = ~qed_valid | (orig_data==dup_data).
- Flush: FIFO cleared, FSM -> IDLE unless DONE (DONE kept), taint cleared, captures held. Pops in the flush cycle are ignored.
- valid_out with an empty FIFO and no push: set err_out (sticky), data ignored, no pop.
- Reset mid-operation: full reinitialisation in the same cycle; ren_out forced 0.
- clk_en=0: no push, no pop, no FSM change; combinational outputs still follow their inputs, but ren_out is gated by clk_en.

Decomposition:
- Package aqed_rd_pkg:
  - tag typedef (TAG_NONE=00, TAG_ORIG=10, TAG_DUP=01);
  - FSM state enum (IDLE, ORIG, DUP, DONE).
- One sub-module aqed_tag_fifo (param DEPTH, WIDTH=2):
  - synchronous push/pop;
  - full/empty/count;
  - clear input for flush.

Test Plan:
- Basic pass: exec_dup with read of 0x05 (mem=0xBEEF), then return latency 2, no writes -> dup read of 0x05 issued the cycle after the original; qed_done=1, qed_valid=1, qed_check=1.
- Mismatch: same sequence, model returns 0xBEEF then 0xBEEE -> qed_done=1, qed_valid=1, qed_check=0.
- Taint: wen_in=1 between the original and duplicate issue, data differs -> qed_done=1, qed_valid=0, qed_check=1.
- Backpressure:
  - with 4 reads outstanding and no returns, stall_out=1 and ren_out=0;
  - a valid_out in the next cycle with ren_in held -> push and pop together, count stays 4, ren_out=1.
- Priority: ren_in=1 on addr 0x10 in the cycle after the original -> ren_out issues orig_addr, stall_out=1; addr 0x10 is issued the following cycle with tag 00.
- Flush/reset: flush in ORIG with 2 outstanding -> FIFO empty, FSM IDLE, later valid_out sets err_out=1; reset clears err_out to 0.

Source files
------------

// File: rtl/aqed_rd_pkg.sv
// Shared types for the read-side A-QED duplicate checker.
package aqed_rd_pkg;

  localparam int unsigned TAG_W = 2;

  // Per-read tag, stored as {is_orig, is_dup}.
  typedef enum logic [TAG_W-1:0] {
    TAG_NONE = 2'b00,
    TAG_DUP  = 2'b01,
    TAG_ORIG = 2'b10
  } tag_e;

  typedef enum logic [1:0] {
    IDLE,
    ORIG,
    DUP,
    DONE
  } state_e;

endpackage

// File: rtl/aqed_tag_fifo.sv
// In-order tag FIFO for outstanding reads; empty-FIFO push+pop bypasses the storage.
module aqed_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // A pop of an empty FIFO is only issued together with a push, so hand back the new tag.
  assign rdata = empty ? wdata : mem_q[rd_ptr_q];

endmodule

// File: rtl/aqed_rd_dup.sv
// Read-side A-QED: re-issues one tagged read as a duplicate and compares both returned words.
module aqed_rd_dup
  import aqed_rd_pkg::*;
#(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic          exec_dup,
  input  logic          ren_in,
  input  logic [AW-1:0] addr_in,
  input  logic          wen_in,
  output logic          ren_out,
  output logic [AW-1:0] addr_out,
  input  logic          valid_out,
  input  logic [DW-1:0] data_out_in,
  output logic          stall_out,
  output logic          qed_done,
  output logic          qed_valid,
  output logic          qed_check,
  output logic          err_out
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    orig_addr_q, orig_addr_d;
  logic [DW-1:0]    orig_data_q, orig_data_d;
  logic [DW-1:0]    dup_data_q, dup_data_d;
  logic             taint_q, taint_d;
  logic             err_q, err_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [TAG_W-1:0] pop_tag;
  tag_e             push_tag;
  logic             push;
  logic             pop;
  logic             fifo_stall;
  logic             dup_pending;
  logic             flush_en;

  // Full FIFO only blocks issue when no pop frees a slot in the same cycle.
  assign fifo_stall  = fifo_full & ~(valid_out & clk_en & ~flush);
  assign dup_pending = (state_q == ORIG);
  assign stall_out   = fifo_stall | dup_pending;
  assign ren_out     = clk_en & ~reset & ~flush & ~fifo_stall & (ren_in | dup_pending);
  assign addr_out    = dup_pending ? orig_addr_q : addr_in;
  assign push        = ren_out;
  assign pop         = valid_out & clk_en & ~flush & (~fifo_empty | push);
  assign flush_en    = flush & clk_en;

  always_comb begin
    push_tag = TAG_NONE;
    if (state_q == IDLE && exec_dup) begin
      push_tag = TAG_ORIG;
    end else if (state_q == ORIG) begin
      push_tag = TAG_DUP;
    end
  end

  aqed_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_en),
    .push  (push),
    .wdata (push_tag),
    .pop   (pop),
    .rdata (pop_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    orig_addr_d = orig_addr_q;
    orig_data_d = orig_data_q;
    dup_data_d  = dup_data_q;
    taint_d     = taint_q;
    // A return with nothing outstanding is a protocol error, not data.
    err_d       = err_q | (valid_out & clk_en & ~flush & (fifo_count == '0) & ~push);

    if (pop && pop_tag == TAG_ORIG) begin
      orig_data_d = data_out_in;
    end
    if (pop && pop_tag == TAG_DUP) begin
      dup_data_d = data_out_in;
    end

    case (state_q)
      IDLE: begin
        if (exec_dup && ren_out) begin
          orig_addr_d = addr_in;
          taint_d     = wen_in & clk_en;
          state_d     = ORIG;
        end
      end
      ORIG: begin
        taint_d = taint_q | (wen_in & clk_en);
        if (ren_out) begin
          state_d = (pop && pop_tag == TAG_DUP) ? DONE : DUP;
        end
      end
      DUP: begin
        if (pop && pop_tag == TAG_DUP) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (flush_en) begin
      if (state_q != DONE) begin
        state_d = IDLE;
      end
      taint_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      orig_addr_q <= '0;
      orig_data_q <= '0;
      dup_data_q  <= '0;
      taint_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      orig_addr_q <= orig_addr_d;
      orig_data_q <= orig_data_d;
      dup_data_q  <= dup_data_d;
      taint_q     <= taint_d;
      err_q       <= err_d;
    end
  end

  assign qed_done  = (state_q == DONE);
  assign qed_valid = qed_done & ~taint_q;
  assign qed_check = ~qed_valid | (orig_data_q == dup_data_q);
  assign err_out   = err_q;

endmodule

// File: tb/tb_aqed_rd_dup.sv
// Self-checking bench for aqed_rd_dup with an in-order memory core model.
module tb_aqed_rd_dup;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MAX_OUT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic          exec_dup;
  logic          ren_in;
  logic [AW-1:0] addr_in;
  logic          wen_in;
  logic          ren_out;
  logic [AW-1:0] addr_out;
  logic          valid_out;
  logic [DW-1:0] data_out_in;
  logic          stall_out;
  logic          qed_done;
  logic          qed_valid;
  logic          qed_check;
  logic          err_out;

  always #5 clk = ~clk;

  aqed_rd_dup #(
    .AW      (AW),
    .DW      (DW),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .flush       (flush),
    .exec_dup    (exec_dup),
    .ren_in      (ren_in),
    .addr_in     (addr_in),
    .wen_in      (wen_in),
    .ren_out     (ren_out),
    .addr_out    (addr_out),
    .valid_out   (valid_out),
    .data_out_in (data_out_in),
    .stall_out   (stall_out),
    .qed_done    (qed_done),
    .qed_valid   (qed_valid),
    .qed_check   (qed_check),
    .err_out     (err_out)
  );

  // Core model: memory contents plus queue of issued reads awaiting return.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];
  int            cyc;
  int            lat;
  bit            core_on;
  int            ret_idx;
  int            flip_idx;
  logic [DW-1:0] flip_mask;

  logic          obs_ren;
  logic          obs_stall;
  logic [AW-1:0] obs_addr;

  int n_tests;
  int n_fail;

  // One clock: core returns, sample issue, advance past the edge.
  task automatic tick();
    if (core_on && clk_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      valid_out   = 1'b1;
      data_out_in = mem[pend_addr[0]] ^ ((ret_idx == flip_idx) ? flip_mask : '0);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      ret_idx++;
    end else begin
      valid_out   = 1'b0;
      data_out_in = DW'($urandom);
    end
    #2;
    obs_ren   = ren_out;
    obs_addr  = addr_out;
    obs_stall = stall_out;
    if (ren_out) begin
      pend_addr.push_back(addr_out);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    clk_en   = 1'b1;
    flush    = 1'b0;
    exec_dup = 1'b0;
    ren_in   = 1'b0;
    wen_in   = 1'b0;
    core_on  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    ret_idx  = 0;
    flip_idx = -1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    clk_en   = 1'b1;
    flush    = 1'b0;
    exec_dup = 1'b1;
    ren_in   = 1'b1;
    addr_in  = AW'($urandom);
    wen_in   = 1'b0;
    core_on  = 1'b0;
    tick();
    n_tests++;
    if (obs_ren !== 1'b0) begin
      n_fail++; $display("FAIL reset_ren: ren_out=%0b expected 0", obs_ren);
    end
    tick();
    n_tests++;
    if (qed_done !== 1'b0 || qed_valid !== 1'b0 || qed_check !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_qed: done/valid/check=%0b%0b%0b expected 001",
               qed_done, qed_valid, qed_check);
    end
    n_tests++;
    if (err_out !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_stall: err=%0b stall=%0b expected 0 0", err_out, stall_out);
    end
    reset    = 1'b0;
    exec_dup = 1'b0;
    ren_in   = 1'b0;
    #1;
    n_tests++;
    if (ren_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_ren: ren_out=%0b expected 0", ren_out);
    end
    pend_addr.delete();
    pend_due.delete();
  endtask

  // wen_at: -1 none, 0 original-issue cycle, 1 duplicate-issue cycle, 2 cycle after.
  task automatic test_check(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] mask, input int wen_at, input int l,
                            input string name);
    bit exp_valid;
    bit exp_check;
    int n;
    do_reset();
    mem[a]    = d;
    lat       = l;
    core_on   = 1'b1;
    flip_idx  = 1;
    flip_mask = mask;
    exp_valid = !(wen_at == 0 || wen_at == 1);
    exp_check = !exp_valid || (mask == '0);

    exec_dup = 1'b1; ren_in = 1'b1; addr_in = a; wen_in = (wen_at == 0);
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== a) begin
      n_fail++;
      $display("FAIL %s_orig_issue: ren=%0b addr=%h expected 1 %h", name, obs_ren, obs_addr, a);
    end
    exec_dup = 1'b0; ren_in = 1'b0; addr_in = AW'($urandom); wen_in = (wen_at == 1);
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== a) begin
      n_fail++;
      $display("FAIL %s_dup_issue: ren=%0b addr=%h expected 1 %h", name, obs_ren, obs_addr, a);
    end
    wen_in = (wen_at == 2);
    tick();
    wen_in = 1'b0;
    n = 0;
    while (!qed_done && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (qed_done !== 1'b1) begin
      n_fail++; $display("FAIL %s_done: qed_done=%0b expected 1 within 20 cycles", name, qed_done);
    end else if (qed_valid !== exp_valid || qed_check !== exp_check) begin
      n_fail++;
      $display("FAIL %s_result: valid=%0b check=%0b expected %0b %0b",
               name, qed_valid, qed_check, exp_valid, exp_check);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    lat     = 1;
    core_on = 1'b0;
    ren_in  = 1'b1;
    for (int i = 0; i < MAX_OUT; i++) begin
      addr_in = AW'($urandom);
      tick();
    end
    addr_in = AW'($urandom);
    tick();
    n_tests++;
    if (obs_ren !== 1'b0 || obs_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: ren=%0b stall=%0b expected 0 1", obs_ren, obs_stall);
    end
    core_on = 1'b1;
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_push_pop: ren=%0b stall=%0b expected 1 0", obs_ren, obs_stall);
    end
    core_on = 1'b0;
    tick();
    n_tests++;
    if (obs_ren !== 1'b0 || obs_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_still_full: ren=%0b stall=%0b expected 0 1", obs_ren, obs_stall);
    end
    ren_in  = 1'b0;
    core_on = 1'b1;
    n = 0;
    while (pend_due.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    n_tests++;
    if (pend_due.size() != 0 || err_out !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: pending=%0d err=%0b stall=%0b expected 0 0 0",
               pend_due.size(), err_out, stall_out);
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] a;
    int n;
    do_reset();
    a = AW'($urandom_range(32, 511));
    mem[a]     = DW'($urandom);
    mem[9'h10] = ~mem[a];
    lat     = 2;
    core_on = 1'b1;
    exec_dup = 1'b1; ren_in = 1'b1; addr_in = a;
    tick();
    exec_dup = 1'b0; addr_in = 9'h10;
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== a || obs_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_dup_first: ren=%0b addr=%h stall=%0b expected 1 %h 1",
               obs_ren, obs_addr, obs_stall, a);
    end
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== 9'h10 || obs_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_req_next: ren=%0b addr=%h stall=%0b expected 1 010 0",
               obs_ren, obs_addr, obs_stall);
    end
    ren_in = 1'b0;
    n = 0;
    while (pend_due.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    n_tests++;
    if (qed_done !== 1'b1 || qed_valid !== 1'b1 || qed_check !== 1'b1 || err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_result: done/valid/check/err=%0b%0b%0b%0b expected 1110",
               qed_done, qed_valid, qed_check, err_out);
    end
  endtask

  task automatic test_clk_en();
    logic [AW-1:0] a;
    int n;
    do_reset();
    a = AW'($urandom);
    mem[a]  = DW'($urandom);
    lat     = 2;
    core_on = 1'b1;
    exec_dup = 1'b1; ren_in = 1'b1; addr_in = a;
    tick();
    exec_dup = 1'b0; addr_in = a ^ 9'h1; clk_en = 1'b0; wen_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (obs_ren !== 1'b0) begin
        n_fail++; $display("FAIL clken_gate_%0d: ren_out=%0b expected 0", i, obs_ren);
      end
    end
    clk_en = 1'b1; wen_in = 1'b0; ren_in = 1'b0;
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== a) begin
      n_fail++;
      $display("FAIL clken_dup: ren=%0b addr=%h expected 1 %h", obs_ren, obs_addr, a);
    end
    n = 0;
    while (!qed_done && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (qed_done !== 1'b1 || qed_valid !== 1'b1 || qed_check !== 1'b1) begin
      n_fail++;
      $display("FAIL clken_result: done/valid/check=%0b%0b%0b expected 111",
               qed_done, qed_valid, qed_check);
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] a;
    logic [AW-1:0] c;
    do_reset();
    a = AW'($urandom);
    c = a ^ 9'h0A5;
    lat     = 1;
    core_on = 1'b0;
    ren_in = 1'b1; addr_in = AW'($urandom);
    tick();
    exec_dup = 1'b1; addr_in = a;
    tick();
    exec_dup = 1'b0; ren_in = 1'b0; flush = 1'b1;
    tick();
    n_tests++;
    if (obs_ren !== 1'b0) begin
      n_fail++; $display("FAIL flush_ren: ren_out=%0b expected 0", obs_ren);
    end
    flush = 1'b0;
    n_tests++;
    if (stall_out !== 1'b0 || qed_done !== 1'b0 || err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: stall/done/err=%0b%0b%0b expected 000",
               stall_out, qed_done, err_out);
    end
    core_on = 1'b1;
    tick();
    n_tests++;
    if (err_out !== 1'b1) begin
      n_fail++; $display("FAIL flush_err: err_out=%0b expected 1", err_out);
    end
    core_on = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exec_dup = 1'b1; ren_in = 1'b1; addr_in = c;
    tick();
    exec_dup = 1'b0; ren_in = 1'b0; addr_in = a;
    tick();
    n_tests++;
    if (obs_ren !== 1'b1 || obs_addr !== c) begin
      n_fail++;
      $display("FAIL flush_rearm: ren=%0b addr=%h expected 1 %h", obs_ren, obs_addr, c);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (err_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_reset_err: err_out=%0b expected 0", err_out);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] rm;
    int            rw;
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    lat         = 2;
    ret_idx     = 0;
    flip_idx    = -1;
    flip_mask   = '0;
    valid_out   = 1'b0;
    data_out_in = '0;
    addr_in     = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'($urandom);
    end

    test_reset();
    test_check(9'h005, 16'hBEEF, 16'h0000, -1, 2, "basic");
    test_check(9'h005, 16'hBEEF, 16'h0001, -1, 2, "mismatch");
    test_check(9'h005, 16'hBEEF, 16'h0001, 1, 2, "taint_dup_cycle");
    test_check(9'h005, 16'hBEEF, 16'h0001, 0, 2, "taint_orig_cycle");
    test_check(9'h005, 16'hBEEF, 16'h0001, 2, 2, "write_after_window");
    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      rm = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 65535)) : '0;
      rw = $urandom_range(0, 3);
      test_check(ra, rd, rm, rw - 1, $urandom_range(1, 3), "random");
    end
    test_backpressure();
    test_priority();
    test_clk_en();
    test_flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
